// File: rtl/mul_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_ctrl_pkg
// Description : Shared widths, operand/product types and the issue-tag layout
//               for the shared multiplier front end.
// Revision    : 1.0  initial release
// ============================================================================
package mul_ctrl_pkg;

    localparam int OP_W   = 24;
    localparam int PROD_W = 48;
    localparam int MUL_N  = 4;

    typedef logic [OP_W-1:0]   operand_t;
    typedef logic [PROD_W-1:0] product_t;

    // Requester-ID width; a single requester still needs one bit.
    function automatic int idw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW = idw_f(MUL_N);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } mul_tag_t;

endpackage
`default_nettype wire

// File: rtl/mul_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mul_result_fifo
// Description : Synchronous first-word-fall-through FIFO; the output holds the
//               last popped word while empty.
// Revision    : 1.0  initial release
// ============================================================================
module mul_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 50,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    localparam int              c_pw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);
    localparam logic [c_pw-1:0]  c_last = c_pw'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_pw-1:0]  r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_last;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop & (r_count != '0);
    // A full FIFO accepts a push only when the head leaves in the same cycle.
    assign w_do_push = i_push & ((r_count != c_full) | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_pw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_pw'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : r_last;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arbiter
// Description : Round-robin, credit-gated sharing of one non-stallable
//               pipelined 24x24 multiplier; results return in issue order.
// Revision    : 1.0  initial release
// ============================================================================
module mul_share_arbiter
    import mul_ctrl_pkg::*;
#(
    parameter int N          = 4,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [N-1:0]         reqValid,
    output logic [N-1:0]         reqReady,
    input  logic [N-1:0]         reqSigned,
    input  logic [N*OP_W-1:0]    reqA,
    input  logic [N*OP_W-1:0]    reqB,
    output logic                 mulRun,
    output logic                 mulSigned,
    output operand_t             mulA,
    output operand_t             mulB,
    input  product_t             mulOut,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [idw_f(N)-1:0]  rspId,
    output product_t             rspProduct
);

    localparam int c_idw = idw_f(N);
    localparam int c_cw  = $clog2(FIFO_DEPTH + 1);
    localparam int c_fw  = c_idw + PROD_W;

    typedef struct packed {
        logic             valid;
        logic [c_idw-1:0] id;
    } tag_t;

    logic                r_mul_run;
    logic [c_cw-1:0]     r_credits;
    logic [c_idw-1:0]    r_ptr;
    tag_t                r_tag [LATENCY];

    logic                w_grant_vld;
    logic [c_idw-1:0]    w_grant_id;
    logic                w_can_issue;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic [c_fw-1:0]     w_head;
    logic [c_cw-1:0]     w_fifo_count;

    // Search starts just past the last granted requester.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            if (!w_grant_vld && reqValid[c_idw'(idx)]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = c_idw'(idx);
            end
        end
    end

    assign w_can_issue = r_mul_run & (r_credits != '0);
    assign w_issue     = w_grant_vld & w_can_issue;

    always_comb begin
        reqReady  = '0;
        mulA      = '0;
        mulB      = '0;
        mulSigned = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_issue && (w_grant_id == c_idw'(i))) begin
                reqReady[i] = 1'b1;
                mulA        = reqA[i*OP_W +: OP_W];
                mulB        = reqB[i*OP_W +: OP_W];
                mulSigned   = reqSigned[i];
            end
        end
    end

    assign mulRun = r_mul_run;
    assign w_push = r_tag[LATENCY-1].valid;
    assign w_pop  = rspValid & rspReady;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_mul_run <= 1'b0;
            r_credits <= c_cw'(FIFO_DEPTH);
            r_ptr     <= c_idw'(N - 1);
            for (int k = 0; k < LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_mul_run <= 1'b1;
            if (w_issue) begin
                r_ptr <= w_grant_id;
            end
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits - c_cw'(1);
                2'b01:   r_credits <= r_credits + c_cw'(1);
                default: r_credits <= r_credits;
            endcase
            r_tag[0] <= '{valid: w_issue, id: (w_issue ? w_grant_id : '0)};
            for (int k = 1; k < LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Credits reserve a FIFO slot at issue, so a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (resetN && w_push && !w_pop) begin
            assert (w_fifo_count != c_cw'(FIFO_DEPTH));
        end
    end

    mul_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_fw)
    ) u_result_fifo (
        .clk         (clk),
        .i_rst_n     (resetN),
        .i_push      (w_push),
        .i_push_data ({r_tag[LATENCY-1].id, mulOut}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (rspValid),
        .o_count     (w_fifo_count)
    );

    assign rspId      = w_head[c_fw-1 -: c_idw];
    assign rspProduct = w_head[PROD_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_arbiter
// Description : Randomised scoreboard bench with a behavioural multiplier.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul_share_arbiter;

    localparam int N     = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int IDW   = 2;

    logic              clk = 1'b0;
    logic              resetN;
    logic [N-1:0]      reqValid, reqReady, reqSigned;
    logic [N*24-1:0]   reqA, reqB;
    logic              mulRun, mulSigned;
    logic [23:0]       mulA, mulB;
    logic [47:0]       mulOut;
    logic              rspValid, rspReady;
    logic [IDW-1:0]    rspId;
    logic [47:0]       rspProduct;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [47:0]    prod;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    int           last_grant = N - 1;
    int           issued = 0;
    int           popped = 0;
    bit           run_exp = 1'b0;
    bit           run_next = 1'b0;
    logic [N-1:0] last_hs = '0;
    logic [N-1:0] snap_ready;
    logic         snap_run, snap_rsp_valid;
    logic [IDW-1:0] snap_rsp_id;
    logic [47:0]  snap_rsp_prod;

    always #5 clk = ~clk;

    mul_share_arbiter #(.N(N), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqSigned  (reqSigned),
        .reqA       (reqA),
        .reqB       (reqB),
        .mulRun     (mulRun),
        .mulSigned  (mulSigned),
        .mulA       (mulA),
        .mulB       (mulB),
        .mulOut     (mulOut),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspId      (rspId),
        .rspProduct (rspProduct)
    );

    // Behavioural stand-in for the 4-stage multiplier instance.
    logic [47:0] mpipe [LAT];
    always_ff @(posedge clk) begin
        if (mulRun) begin
            mpipe[0] <= {{24{mulSigned & mulA[23]}}, mulA} * {{24{mulSigned & mulB[23]}}, mulB};
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mulOut = mpipe[LAT-1];

    function automatic logic [47:0] golden(input bit s, input logic [23:0] a, input logic [23:0] b);
        logic signed [47:0] ps;
        logic [47:0]        pu;
        ps = 48'($signed(a)) * 48'($signed(b));
        pu = 48'(a) * 48'(b);
        return s ? ps : pu;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic set_op(input int i, input logic [23:0] a, input logic [23:0] b, input bit s);
        reqA[24*i +: 24] = a;
        reqB[24*i +: 24] = b;
        reqSigned[i]     = s;
    endtask

    function automatic logic [23:0] pick();
        case ($urandom_range(7))
            0:       return 24'hFFFFFF;
            1:       return 24'h000000;
            2:       return 24'h800000;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic new_op(input int i);
        set_op(i, pick(), pick(), bit'($urandom_range(1)));
    endtask

    // One clock: model and check at the falling edge, then drive after the rising edge.
    task automatic cycle();
        logic [N-1:0] exp_rr;
        int           idx;
        bit           found;
        @(negedge clk);
        snap_ready     = reqReady;
        snap_run       = mulRun;
        snap_rsp_valid = rspValid;
        snap_rsp_id    = rspId;
        snap_rsp_prod  = rspProduct;
        last_hs        = '0;
        if (!resetN) begin
            expq.delete();
            last_grant = N - 1;
            issued     = 0;
            popped     = 0;
            run_next   = 1'b0;
        end else begin
            exp_rr = '0;
            found  = 1'b0;
            if (run_exp && (issued - popped) < DEPTH) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (last_grant + k) % N;
                    if (!found && reqValid[IDW'(idx)]) begin
                        exp_rr[IDW'(idx)] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            chk(reqReady == exp_rr, "grant", 64'(reqReady), 64'(exp_rr));
            chk(mulRun == run_exp, "mulRun", 64'(mulRun), 64'(run_exp));
            last_hs = reqValid & reqReady;
            for (int i = 0; i < N; i++) begin
                if (last_hs[i]) begin
                    expq.push_back({IDW'(i), golden(reqSigned[i], reqA[24*i +: 24], reqB[24*i +: 24])});
                    last_grant = i;
                    issued++;
                end
            end
            if (rspValid && rspReady) popped++;
            run_next = 1'b1;
        end
        @(posedge clk);
        run_exp = run_next;
        #1;
    endtask

    task automatic do_reset(input int n);
        resetN = 1'b0;
        repeat (n) cycle();
        resetN = 1'b1;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetN && rspValid && rspReady) begin
                if (expq.size() == 0) begin
                    chk(1'b0, "rsp_unexpected", 64'(rspProduct), 64'(0));
                end else begin
                    e = expq.pop_front();
                    chk(rspId == e.id && rspProduct == e.prod, "rsp",
                        64'({rspId, rspProduct}), 64'({e.id, e.prod}));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n, cnt;
        resetN = 1'b0; reqValid = '0; reqSigned = '0; reqA = '0; reqB = '0; rspReady = 1'b1;

        // Reset state
        repeat (3) cycle();
        chk(reqReady == '0, "rst_ready", 64'(reqReady), 64'(0));
        chk(mulRun == 1'b0, "rst_run", 64'(mulRun), 64'(0));
        chk(rspValid == 1'b0, "rst_rspValid", 64'(rspValid), 64'(0));
        chk(rspId == '0 && rspProduct == '0, "rst_rsp", 64'({rspId, rspProduct}), 64'(0));

        // Unsigned max*max from requester 0, latency and value
        resetN = 1'b1;
        set_op(0, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
        reqValid = 4'b0001;
        cycle();
        chk(snap_ready == '0, "ready_after_release", 64'(snap_ready), 64'(0));
        chk(snap_run == 1'b0, "run_after_release", 64'(snap_run), 64'(0));
        cycle();
        chk(snap_run == 1'b1, "run_second_cycle", 64'(snap_run), 64'(1));
        chk(last_hs == 4'b0001, "first_issue", 64'(last_hs), 64'(1));
        reqValid = '0;
        n = 0;
        do begin cycle(); n++; end while (!snap_rsp_valid && n < 20);
        chk(n == 5, "latency", 64'(n), 64'(5));
        chk(snap_rsp_id == 0 && snap_rsp_prod == 48'hFFFFFE000001, "unsigned_max",
            64'({snap_rsp_id, snap_rsp_prod}), 64'({2'd0, 48'hFFFFFE000001}));

        // Signed -1 * 3 from requester 2
        set_op(2, 24'hFFFFFF, 24'h000003, 1'b1);
        reqValid = 4'b0100;
        n = 0;
        do begin cycle(); n++; end while (!last_hs[2] && n < 20);
        chk(last_hs[2] == 1'b1, "signed_issue", 64'(last_hs), 64'(4));
        reqValid = '0;
        n = 0;
        do begin cycle(); n++; end while (!snap_rsp_valid && n < 20);
        chk(snap_rsp_id == 2 && snap_rsp_prod == 48'hFFFFFFFFFFFD, "signed_neg",
            64'({snap_rsp_id, snap_rsp_prod}), 64'({2'd2, 48'hFFFFFFFFFFFD}));

        // All requesters continuously valid: 0,1,2,3,0,...
        do_reset(2);
        for (int i = 0; i < N; i++) new_op(i);
        reqValid = '1;
        cnt = 0; n = 0;
        while (cnt < 8 && n < 30) begin
            cycle(); n++;
            for (int i = 0; i < N; i++) begin
                if (last_hs[i]) begin
                    chk(i == cnt % N, "rr_order", 64'(i), 64'(cnt % N));
                    cnt++;
                    new_op(i);
                end
            end
        end
        chk(cnt == 8, "rr_count", 64'(cnt), 64'(8));
        reqValid = '0;
        repeat (15) cycle();

        // Credit exhaustion with backpressure
        rspReady = 1'b0;
        do_reset(2);
        new_op(0); reqValid = 4'b0001;
        cnt = 0;
        repeat (16) begin
            cycle();
            if (last_hs[0]) begin cnt++; new_op(0); end
        end
        chk(cnt == 8, "credit_issues", 64'(cnt), 64'(8));
        chk(snap_ready == '0, "credit_stall", 64'(snap_ready), 64'(0));
        rspReady = 1'b1;
        cycle();
        rspReady = 1'b0;
        cycle();
        chk(last_hs[0] == 1'b1, "credit_return_issue", 64'(last_hs), 64'(1));
        new_op(0);
        cnt = 0;
        repeat (5) begin
            cycle();
            if (last_hs[0]) begin cnt++; new_op(0); end
        end
        chk(cnt == 0, "credit_no_extra", 64'(cnt), 64'(0));
        reqValid = '0; rspReady = 1'b1;
        repeat (20) cycle();
        chk(popped == 9 && expq.size() == 0, "credit_drain", 64'(popped), 64'(9));

        // Reset with work in flight and queued
        rspReady = 1'b0;
        new_op(0); reqValid = 4'b0001;
        cnt = 0; n = 0;
        while (cnt < 5 && n < 20) begin
            cycle(); n++;
            if (last_hs[0]) begin cnt++; new_op(0); end
        end
        reqValid = '0;
        cycle();
        do_reset(2);
        rspReady = 1'b1;
        cnt = 0;
        repeat (12) begin cycle(); if (snap_rsp_valid) cnt++; end
        chk(cnt == 0, "no_stale", 64'(cnt), 64'(0));
        rspReady = 1'b0;
        new_op(0); reqValid = 4'b0001;
        cnt = 0;
        repeat (16) begin
            cycle();
            if (last_hs[0]) begin cnt++; new_op(0); end
        end
        chk(cnt == 8, "credits_restored", 64'(cnt), 64'(8));
        reqValid = '0; rspReady = 1'b1;
        repeat (20) cycle();

        // Randomised traffic with one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset(2);
            for (int i = 0; i < N; i++) begin
                if (last_hs[i] || !reqValid[i]) begin
                    if ($urandom_range(99) < 60) begin reqValid[i] = 1'b1; new_op(i); end
                    else reqValid[i] = 1'b0;
                end
            end
            rspReady = ($urandom_range(99) < 70);
            cycle();
        end
        reqValid = '0; rspReady = 1'b1;
        repeat (40) cycle();
        chk(expq.size() == 0, "final_drain", 64'(expq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
